mult_err_monitor: RTL

Sequential error-statistics stage that sits directly downstream of the 8x8 approximate array multiplier. Each cycle it accepts one operand pair and the multiplier's approximate product, and computes the exact product internally. Over a fixed window of samples it accumulates the error distance (ED): sample count with nonzero ED, maximum ED, and sum of ED. Results are held stable for readout when the window completes.

---
 rtl/mult_err_pkg.sv | 16 +
 rtl/mult_err_dist_pipe.sv | 72 +++++++
 rtl/mult_err_monitor.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mult_err_pkg.sv
// Shared types and constants for the multiplier error monitor.
// Holds the FSM state enum, default sizes and the drain length.
package mult_err_pkg;

  localparam int unsigned DEF_WIDTH       = 8;
  localparam int unsigned DEF_SAMPLE_LOG2 = 8;
  localparam int unsigned DRAIN_CYCLES    = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/mult_err_dist_pipe.sv
// Two-stage error-distance datapath: |a*b - p_approx|.
// Ports: clk, rst_n, a, b, p_approx, valid -> ed, ed_valid.
module err_dist_pipe
  import mult_err_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2*WIDTH-1:0] p_approx,
  input  logic               valid,
  output logic [2*WIDTH-1:0] ed,
  output logic               ed_valid
);

  localparam int PW = 2 * WIDTH;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [PW-1:0]    p_q;
  logic             v1_q;

  logic [PW-1:0]    ed_q;
  logic [PW-1:0]    ed_d;
  logic             v2_q;

  logic [PW-1:0]    prod;
  logic [PW:0]      diff;
  logic [PW-1:0]    diff_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      p_q  <= '0;
      v1_q <= 1'b0;
    end else begin
      a_q  <= a;
      b_q  <= b;
      p_q  <= p_approx;
      v1_q <= valid;
    end
  end

  assign prod    = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
  assign diff    = {1'b0, prod} - {1'b0, p_q};
  assign diff_lo = diff[PW-1:0];

  // |diff| < 2**PW, so negating the low PW bits gives the magnitude.
  always_comb begin
    ed_d = diff_lo;
    if (diff[PW]) begin
      ed_d = ~diff_lo + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ed_q <= '0;
      v2_q <= 1'b0;
    end else begin
      ed_q <= ed_d;
      v2_q <= v1_q;
    end
  end

  assign ed       = ed_q;
  assign ed_valid = v2_q;

endmodule

// File: rtl/mult_err_monitor.sv
// Windowed error statistics for the approximate multiplier.
// Ports: start/in_valid/a/b/p_approx in; in_ready/busy/done/err_* out.
module mult_err_monitor
  import mult_err_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SAMPLE_LOG2 = DEF_SAMPLE_LOG2,
  parameter int ACC_W       = 2 * WIDTH + SAMPLE_LOG2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  input  logic [2*WIDTH-1:0]     p_approx,
  output logic                   busy,
  output logic                   done,
  output logic [SAMPLE_LOG2:0]   err_count,
  output logic [2*WIDTH-1:0]     err_max,
  output logic [ACC_W-1:0]       err_sum
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = SAMPLE_LOG2 + 1;
  localparam logic [CW-1:0] LAST  = CW'((2 ** SAMPLE_LOG2) - 1);
  localparam logic [1:0]    DLAST = 2'(DRAIN_CYCLES - 1);

  state_e        state_q;
  state_e        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [1:0]    drn_q;
  logic [1:0]    drn_d;

  logic          accept;
  logic          clr;
  logic [PW-1:0] ed;
  logic          ed_valid;

  logic [CW-1:0]    cnt_err_q;
  logic [PW-1:0]    max_q;
  logic [ACC_W-1:0] sum_q;

  assign in_ready = (state_q == RUN);
  assign busy     = (state_q == RUN) || (state_q == DRAIN);
  assign done     = (state_q == DONE);

  assign accept = in_valid && in_ready;
  assign clr    = start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drn_d   = drn_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (accept) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_d = DRAIN;
            drn_d   = '0;
          end
        end
      end
      DRAIN: begin
        if (drn_q == DLAST) begin
          state_d = DONE;
        end else begin
          drn_d = drn_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      drn_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drn_q   <= drn_d;
    end
  end

  err_dist_pipe #(
    .WIDTH (WIDTH)
  ) u_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .p_approx (p_approx),
    .valid    (accept),
    .ed       (ed),
    .ed_valid (ed_valid)
  );

  // The pipe is always empty when a start is honoured, so clearing
  // never drops a retiring sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_err_q <= '0;
      max_q     <= '0;
      sum_q     <= '0;
    end else if (clr) begin
      cnt_err_q <= '0;
      max_q     <= '0;
      sum_q     <= '0;
    end else if (ed_valid) begin
      sum_q <= sum_q + ACC_W'(ed);
      if (ed > max_q) begin
        max_q <= ed;
      end
      if (|ed) begin
        cnt_err_q <= cnt_err_q + CW'(1);
      end
    end
  end

  assign err_count = cnt_err_q;
  assign err_max   = max_q;
  assign err_sum   = sum_q;

endmodule
